// File: rtl/alu_frame_ctrl.sv
// Frame sequencer between the byte-stream RX/TX blocks and a combinational ALU.
// It collects the bytes A, B and OP, drives the ALU and returns the result as one TX byte.
module alu_frame_ctrl #(
  parameter int NB_DATA = 6,
  parameter int NB_OP   = 6,
  parameter int TIMEOUT = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  input  logic [NB_DATA-1:0] alu_result,
  output logic [NB_DATA-1:0] Data_A,
  output logic [NB_DATA-1:0] Data_B,
  output logic [NB_OP-1:0]   Op,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_done,
  output logic               busy,
  output logic               overrun,
  output logic               timeout
);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX} state_t;

  state_t        state, nstate;
  logic [TW-1:0] timer;
  logic          expire, in_frame, in_out, op_ok;
  logic          unused_rx;

  // Only the low bits of each byte are meaningful for narrow parameterizations.
  assign unused_rx = ^rx_data;

  assign expire   = (timer == TW'(TIMEOUT - 1));
  assign in_frame = (state == WAIT_B) || (state == WAIT_OP);
  assign in_out   = (state == EXEC) || (state == SEND) || (state == WAIT_TX);

  always_comb begin
    case (Op)
      NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100), NB_OP'(6'b100101),
      NB_OP'(6'b100110), NB_OP'(6'b000011), NB_OP'(6'b000010), NB_OP'(6'b100111):
        op_ok = 1'b1;
      default: op_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_A;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      WAIT_A:  if (rx_valid) nstate = WAIT_B;
      WAIT_B:  if (rx_valid) nstate = WAIT_OP; else if (expire) nstate = WAIT_A;
      WAIT_OP: if (rx_valid) nstate = EXEC;    else if (expire) nstate = WAIT_A;
      EXEC:    nstate = SEND;
      SEND:    nstate = WAIT_TX;
      WAIT_TX: if (tx_done) nstate = WAIT_A;
      default: nstate = WAIT_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Data_A   <= '0;
      Data_B   <= '0;
      Op       <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
      timeout  <= 1'b0;
      timer    <= '0;
    end else begin
      tx_start <= (state == SEND);
      busy     <= (nstate != WAIT_A);
      overrun  <= rx_valid && in_out;
      // A byte arriving on the expiry cycle wins over the abort.
      timeout  <= in_frame && !rx_valid && expire;
      if (in_frame && !rx_valid)
        timer <= expire ? '0 : timer + 1'b1;
      case (state)
        WAIT_A:  if (rx_valid) begin Data_A <= rx_data[NB_DATA-1:0]; timer <= '0; end
        WAIT_B:  if (rx_valid) begin Data_B <= rx_data[NB_DATA-1:0]; timer <= '0; end
        WAIT_OP: if (rx_valid) begin Op     <= rx_data[NB_OP-1:0];   timer <= '0; end
        EXEC:    tx_data <= op_ok ? 8'(alu_result) : 8'hFF;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_frame_ctrl.sv
// Directed bench for alu_frame_ctrl with a behavioural ALU and a tx_data scoreboard.
module tb_alu_frame_ctrl;
  localparam int NB_DATA = 6;
  localparam int NB_OP   = 6;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [7:0]         rx_data = '0;
  logic               rx_valid = 1'b0;
  logic [NB_DATA-1:0] alu_result;
  logic [NB_DATA-1:0] Data_A, Data_B;
  logic [NB_OP-1:0]   Op;
  logic [7:0]         tx_data;
  logic               tx_start, busy, overrun, timeout;
  logic               tx_done = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb[$];

  alu_frame_ctrl #(.NB_DATA(NB_DATA), .NB_OP(NB_OP), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .alu_result(alu_result), .Data_A(Data_A), .Data_B(Data_B), .Op(Op),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .busy(busy), .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (Op)
      6'b100000: alu_result = Data_A + Data_B;
      6'b100010: alu_result = Data_A - Data_B;
      6'b100100: alu_result = Data_A & Data_B;
      6'b100101: alu_result = Data_A | Data_B;
      6'b100110: alu_result = Data_A ^ Data_B;
      6'b000011: alu_result = $signed(Data_A) >>> Data_B;
      6'b000010: alu_result = Data_A >> Data_B;
      6'b100111: alu_result = ~(Data_A | Data_B);
      default:   alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Sends a frame, waits (bounded) for tx_start and compares against the scoreboard.
  task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [7:0] exp);
    int n;
    logic [7:0] want;
    send_byte(a); send_byte(b); send_byte(op);
    sb.push_back(exp);
    n = 0;
    while (!tx_start && n < 10) begin @(negedge clk); n++; end
    check({tag, "_latency"}, n, 2);
    want = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
    check({tag, "_tx_data"}, tx_data, want);
    @(negedge clk);
    check({tag, "_tx_start_pulse"}, tx_start, 0);
  endtask

  task automatic finish_tx(input string tag);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int first, cnt;
    logic [7:0] held;
    repeat (2) @(negedge clk);
    check("reset_outputs", {Data_A, Data_B, Op, tx_data, tx_start, busy, overrun, timeout}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    tx_done = 1'b1; @(negedge clk); tx_done = 1'b0;
    check("tx_done_ignored", busy, 0);

    // 1: ADD
    run_frame("add", 8'd15, 8'd20, 8'h20, 8'h23);
    check("add_data_a", Data_A, 15);
    check("add_data_b", Data_B, 20);
    check("add_busy", busy, 1);
    finish_tx("add");

    // 2: back-to-back SUB, SRA
    run_frame("sub", 8'd20, 8'd15, 8'h22, 8'h05);
    finish_tx("sub");
    run_frame("sra", 8'd20, 8'd3, 8'h03, 8'h02);
    finish_tx("sra");

    // 3: invalid op, then NOR
    run_frame("badop", 8'd15, 8'd20, 8'h3F, 8'hFF);
    finish_tx("badop");
    run_frame("nor", 8'd15, 8'd20, 8'h27, 8'h20);
    finish_tx("nor");

    // 4: partial frame abort
    send_byte(8'd5);
    check("to_busy", busy, 1);
    first = 0; cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (timeout) begin cnt++; if (first == 0) first = i; end
    end
    check("to_cycle", first, 16);
    check("to_count", cnt, 1);
    check("to_busy_after", busy, 0);
    check("to_data_a_kept", Data_A, 5);
    run_frame("or", 8'd5, 8'd1, 8'h25, 8'h05);

    // 5: overrun in WAIT_TX, including one coincident with tx_done
    held = tx_data;
    send_byte(8'h11);
    check("ovr_pulse", overrun, 1);
    check("ovr_busy", busy, 1);
    @(negedge clk);
    check("ovr_single", overrun, 0);
    rx_data = 8'h22; rx_valid = 1'b1; tx_done = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; tx_done = 1'b0;
    check("ovr_done_pulse", overrun, 1);
    check("ovr_done_idle", busy, 0);
    check("ovr_tx_data", tx_data, held);
    run_frame("and", 8'd12, 8'd10, 8'h24, 8'h08);
    finish_tx("and");

    // 6: reset in WAIT_OP, then in SEND
    send_byte(8'd15); send_byte(8'd20);
    #2 rst_n = 1'b0;
    #1 check("rst_waitop", {Data_A, Data_B, Op, tx_data, tx_start, busy, overrun, timeout}, 0);
    @(negedge clk); rst_n = 1'b1;
    send_byte(8'd15); send_byte(8'd20); send_byte(8'h26);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_send", {Data_A, Data_B, Op, tx_data, tx_start, busy, overrun, timeout}, 0);
    @(negedge clk); rst_n = 1'b1;
    cnt = 0;
    repeat (6) begin @(negedge clk); if (tx_start) cnt++; end
    check("rst_no_resend", cnt, 0);
    run_frame("xor", 8'd15, 8'd20, 8'h26, 8'h1B);

    // tx_start must drop with reset, not on the next edge
    send_byte(8'h00);
    #2 rst_n = 1'b0;
    #1 check("rst_wait_tx", {busy, tx_data}, 0);
    @(negedge clk); rst_n = 1'b1;
    run_frame("srl", 8'd40, 8'd2, 8'h02, 8'h0A);
    #6 rst_n = 1'b0;
    #1 check("rst_tx_start_async", tx_start, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
